// File: rtl/state_dump_unit_if.sv
// state_dump_unit_if
// Beat stream carried from the state dump engine to its sink.
//   out_valid  : beat available (engine -> sink)
//   out_ready  : sink accepts the beat (sink -> engine)
//   out_data   : 32-bit beat payload
//   out_kind   : 0 = PC, 1 = register, 2 = data-memory word
//   out_index  : register number or data-memory word number (0 for PC)
// The master modport is the engine side and the slave modport is the sink side.
`timescale 1ns/1ps
interface state_dump_unit_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_kind;
    logic [7:0]  out_index;

    modport master (
        output out_valid,
        output out_data,
        output out_kind,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_kind,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/state_dump_unit.sv
// state_dump_unit
// End-of-run state dump engine for the single-cycle MIPS core.  A start pulse
// in IDLE captures the PC.  The engine then walks the register file through a
// spare read port and assembles big-endian words from the byte-wide
// data-memory read port.  Each item leaves as one 32-bit beat on a
// valid/ready stream.  The beat order is PC, R0..R31, DM0..DM(DM_WORDS-1).
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   start      : begin a dump (honoured only in IDLE)
//   pc_in      : program counter captured on an accepted start
//   rf_raddr   : register-file read address, with rf_rdata as its combinational data
//   dm_addr    : data-memory byte address, with dm_rdata as its combinational byte
//   busy       : dump in progress
//   done       : one-cycle pulse after the final beat is accepted
//   dump       : beat stream (master side of state_dump_unit_if)
`timescale 1ns/1ps
module state_dump_unit #(
    parameter int          DM_WORDS = 9,
    parameter logic [31:0] DM_BASE  = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [31:0]              pc_in,
    output logic [4:0]               rf_raddr,
    input  logic [31:0]              rf_rdata,
    output logic [31:0]              dm_addr,
    input  logic [7:0]               dm_rdata,
    output logic                     busy,
    output logic                     done,
    state_dump_unit_if.master        dump
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PC_SEND = 3'd1;
    localparam logic [2:0] ST_RF_LOAD = 3'd2;
    localparam logic [2:0] ST_RF_SEND = 3'd3;
    localparam logic [2:0] ST_DM_BYTE = 3'd4;
    localparam logic [2:0] ST_DM_SEND = 3'd5;
    localparam logic [2:0] ST_FINISH  = 3'd6;

    localparam logic [7:0] LAST_WORD = 8'(DM_WORDS - 1);

    // Shift a new byte in at the bottom so byte 0 of a word ends in bits 31:24.
    function automatic logic [31:0] shift_in_byte(input logic [31:0] acc, input logic [7:0] b);
        return {acc[23:0], b};
    endfunction

    logic [2:0]  state_r;
    logic [4:0]  idx_r;
    logic [7:0]  word_r;
    logic [1:0]  byte_r;
    logic [31:0] acc_r;
    logic        out_valid_r;
    logic [31:0] out_data_r;
    logic [1:0]  out_kind_r;
    logic [7:0]  out_index_r;
    logic        busy_r;
    logic        done_r;
    logic [4:0]  rf_raddr_r;
    logic [31:0] dm_addr_r;
    logic        hs_s;
    logic [31:0] assembled_s;

    assign hs_s        = out_valid_r & dump.out_ready;
    assign assembled_s = shift_in_byte(acc_r, dm_rdata);

    assign dump.out_valid = out_valid_r;
    assign dump.out_data  = out_data_r;
    assign dump.out_kind  = out_kind_r;
    assign dump.out_index = out_index_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign rf_raddr       = rf_raddr_r;
    assign dm_addr        = dm_addr_r;

    // Dump sequencer: read addresses are loaded one state ahead so they are
    // already stable during the load state that samples the read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= 5'd0;
            word_r      <= 8'd0;
            byte_r      <= 2'd0;
            acc_r       <= 32'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'd0;
            out_kind_r  <= 2'd0;
            out_index_r <= 8'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rf_raddr_r  <= 5'd0;
            dm_addr_r   <= 32'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        out_data_r  <= pc_in;
                        out_kind_r  <= 2'd0;
                        out_index_r <= 8'd0;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_PC_SEND;
                    end
                end
                ST_PC_SEND: begin
                    if (hs_s) begin
                        out_valid_r <= 1'b0;
                        idx_r       <= 5'd0;
                        rf_raddr_r  <= 5'd0;
                        state_r     <= ST_RF_LOAD;
                    end
                end
                ST_RF_LOAD: begin
                    out_data_r  <= rf_rdata;
                    out_kind_r  <= 2'd1;
                    out_index_r <= {3'b000, idx_r};
                    out_valid_r <= 1'b1;
                    state_r     <= ST_RF_SEND;
                end
                ST_RF_SEND: begin
                    if (hs_s) begin
                        out_valid_r <= 1'b0;
                        if (idx_r == 5'd31) begin
                            word_r    <= 8'd0;
                            byte_r    <= 2'd0;
                            dm_addr_r <= DM_BASE;
                            state_r   <= ST_DM_BYTE;
                        end else begin
                            idx_r      <= idx_r + 5'd1;
                            rf_raddr_r <= idx_r + 5'd1;
                            state_r    <= ST_RF_LOAD;
                        end
                    end
                end
                ST_DM_BYTE: begin
                    acc_r <= assembled_s;
                    if (byte_r == 2'd3) begin
                        out_data_r  <= assembled_s;
                        out_kind_r  <= 2'd2;
                        out_index_r <= word_r;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DM_SEND;
                    end else begin
                        byte_r    <= byte_r + 2'd1;
                        dm_addr_r <= dm_addr_r + 32'd1;
                    end
                end
                ST_DM_SEND: begin
                    if (hs_s) begin
                        out_valid_r <= 1'b0;
                        if (word_r == LAST_WORD) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_FINISH;
                        end else begin
                            word_r    <= word_r + 8'd1;
                            byte_r    <= 2'd0;
                            // Still holding byte 3 of the previous word, so +1
                            // lands on byte 0 of the next word.
                            dm_addr_r <= dm_addr_r + 32'd1;
                            state_r   <= ST_DM_BYTE;
                        end
                    end
                end
                ST_FINISH: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_dump_unit.sv
// tb_state_dump_unit
// Directed bench for state_dump_unit.  Instance A uses the default
// configuration, and instance B dumps a single word from byte address 0x100.
// Expected beats, with their acceptance cycles, are queued when a dump starts.
// A negedge monitor pops and compares them as the DUT hands beats over.
`timescale 1ns/1ps
module tb_state_dump_unit;

    typedef struct {
        logic [1:0]  kind;
        logic [7:0]  index;
        logic [31:0] data;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [31:0] pc_a, pc_b;
    logic [4:0]  rf_raddr_a, rf_raddr_b;
    logic [31:0] rf_rdata_a, rf_rdata_b;
    logic [31:0] dm_addr_a, dm_addr_b;
    logic [7:0]  dm_rdata_a, dm_rdata_b;
    logic        busy_a, busy_b, done_a, done_b;

    logic [31:0] rf_mem [32];
    logic [7:0]  dm_mem [512];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc_a = 0, start_cyc_b = 0;
    int done_exp_a = -1, done_exp_b = -1;
    int done_cnt_a = 0, done_cnt_b = 0;
    beat_t qa[$];
    beat_t qb[$];
    beat_t ea, eb;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign rf_rdata_a = rf_mem[rf_raddr_a];
    assign rf_rdata_b = rf_mem[rf_raddr_b];
    assign dm_rdata_a = dm_mem[dm_addr_a[8:0]];
    assign dm_rdata_b = dm_mem[dm_addr_b[8:0]];

    state_dump_unit_if if_a ();
    state_dump_unit_if if_b ();

    state_dump_unit #(.DM_WORDS(9), .DM_BASE(32'h0000_0000)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pc_in(pc_a),
        .rf_raddr(rf_raddr_a), .rf_rdata(rf_rdata_a),
        .dm_addr(dm_addr_a), .dm_rdata(dm_rdata_a),
        .busy(busy_a), .done(done_a), .dump(if_a)
    );

    state_dump_unit #(.DM_WORDS(1), .DM_BASE(32'h0000_0100)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pc_in(pc_b),
        .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b),
        .dm_addr(dm_addr_b), .dm_rdata(dm_rdata_b),
        .busy(busy_b), .done(done_b), .dump(if_b)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue the first 'limit' beats of a dump.  Beats at or after bp_beat are
    // delayed by bp_len cycles of backpressure.
    task automatic push_dump(input int sel, input int n_words, input int base,
                             input logic [31:0] pc, input int limit,
                             input int bp_beat, input int bp_len);
        for (int n = 0; n < 33 + n_words && n < limit; n++) begin
            beat_t b;
            if (n == 0) begin
                b.kind = 2'd0; b.index = 8'd0; b.data = pc; b.cyc = 1;
            end else if (n <= 32) begin
                b.kind = 2'd1; b.index = 8'(n - 1); b.data = rf_mem[n - 1];
                b.cyc = 3 + 2 * (n - 1);
            end else begin
                int w;
                int a;
                w = n - 33;
                a = base + 4 * w;
                b.kind = 2'd2; b.index = 8'(w);
                b.data = {dm_mem[a], dm_mem[a + 1], dm_mem[a + 2], dm_mem[a + 3]};
                b.cyc = 70 + 5 * w;
            end
            if (bp_beat >= 0 && n >= bp_beat) b.cyc = b.cyc + bp_len;
            if (sel == 0) qa.push_back(b);
            else qb.push_back(b);
        end
    endtask

    task automatic compare_beat(input string tag, input beat_t e, input logic [1:0] k,
                                input logic [7:0] i, input logic [31:0] d, input int c);
        checks++;
        assert (k === e.kind && i === e.index && d === e.data && c == e.cyc)
        else begin
            errors++;
            $error("FAIL %s: got kind=%0d idx=%0d data=%h cyc=%0d, expected kind=%0d idx=%0d data=%h cyc=%0d",
                   tag, k, i, d, c, e.kind, e.index, e.data, e.cyc);
        end
    endtask

    // Beat and done monitor for both instances.
    always @(negedge clk) begin
        if (if_a.out_valid && if_a.out_ready) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL beat_a: got unexpected beat kind=%0d idx=%0d data=%h, expected none",
                       if_a.out_kind, if_a.out_index, if_a.out_data);
            end else begin
                ea = qa.pop_front();
                compare_beat("beat_a", ea, if_a.out_kind, if_a.out_index, if_a.out_data,
                             cyc - start_cyc_a);
            end
        end
        if (if_b.out_valid && if_b.out_ready) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL beat_b: got unexpected beat kind=%0d idx=%0d data=%h, expected none",
                       if_b.out_kind, if_b.out_index, if_b.out_data);
            end else begin
                eb = qb.pop_front();
                compare_beat("beat_b", eb, if_b.out_kind, if_b.out_index, if_b.out_data,
                             cyc - start_cyc_b);
            end
        end
        if (done_a) begin
            done_cnt_a++;
            checks++;
            assert (cyc - start_cyc_a == done_exp_a)
            else begin
                errors++;
                $error("FAIL done_a_cycle: got cycle %0d, expected %0d", cyc - start_cyc_a, done_exp_a);
            end
        end
        if (done_b) begin
            done_cnt_b++;
            checks++;
            assert (cyc - start_cyc_b == done_exp_b)
            else begin
                errors++;
                $error("FAIL done_b_cycle: got cycle %0d, expected %0d", cyc - start_cyc_b, done_exp_b);
            end
        end
    end

    task automatic check_zero(input string tag, input int sel);
        logic [81:0] v;
        if (sel == 0)
            v = {if_a.out_valid, if_a.out_data, if_a.out_kind, if_a.out_index,
                 busy_a, done_a, rf_raddr_a, dm_addr_a};
        else
            v = {if_b.out_valid, if_b.out_data, if_b.out_kind, if_b.out_index,
                 busy_b, done_b, rf_raddr_b, dm_addr_b};
        checks++;
        assert (v === 82'd0)
        else begin
            errors++;
            $error("FAIL %s: got outputs %h, expected all zero", tag, v);
        end
    endtask

    // Pulse start for one cycle.  Returns at cycle 1 of the dump.
    task automatic start_run(input int sel, input int limit, input int bp_beat,
                             input int bp_len, input int done_exp);
        if (sel == 0) begin
            start_a = 1'b1;
            start_cyc_a = cyc;
            done_exp_a = done_exp;
            push_dump(0, 9, 0, pc_a, limit, bp_beat, bp_len);
        end else begin
            start_b = 1'b1;
            start_cyc_b = cyc;
            done_exp_b = done_exp;
            push_dump(1, 1, 32'h100, pc_b, limit, bp_beat, bp_len);
        end
        step(1);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int sel, input int base_cnt);
        int n;
        int cnt;
        n = 0;
        cnt = (sel == 0) ? done_cnt_a : done_cnt_b;
        while (cnt == base_cnt && n < 300) begin
            step(1);
            n++;
            cnt = (sel == 0) ? done_cnt_a : done_cnt_b;
        end
        step(3);
        cnt = (sel == 0) ? done_cnt_a : done_cnt_b;
        checks++;
        assert (cnt == base_cnt + 1)
        else begin
            errors++;
            $error("FAIL %s_done_count: got %0d, expected %0d", tag, cnt - base_cnt, 1);
        end
        checks++;
        assert (((sel == 0) ? qa.size() : qb.size()) == 0)
        else begin
            errors++;
            $error("FAIL %s_beats_left: got %0d, expected 0", tag, (sel == 0) ? qa.size() : qb.size());
        end
        checks++;
        assert (((sel == 0) ? {if_a.out_valid, busy_a} : {if_b.out_valid, busy_b}) === 2'b00)
        else begin
            errors++;
            $error("FAIL %s_idle: got valid/busy not 00, expected 00", tag);
        end
    endtask

    initial begin
        int base;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        pc_a = 32'h0000_0040;
        pc_b = 32'h0000_1234;
        if_a.out_ready = 1'b1;
        if_b.out_ready = 1'b1;
        for (int k = 0; k < 32; k++) rf_mem[k] = 32'hC0DE_0000 | (32'(k) * 32'h0001_0103);
        rf_mem[5] = 32'h0000_0019;
        for (int i = 0; i < 512; i++) dm_mem[i] = 8'((i * 7 + 3) & 255);
        dm_mem[0] = 8'h12; dm_mem[1] = 8'h34; dm_mem[2] = 8'h56; dm_mem[3] = 8'h78;
        dm_mem[256] = 8'hAA; dm_mem[257] = 8'hBB; dm_mem[258] = 8'hCC; dm_mem[259] = 8'hDD;

        step(3);
        check_zero("reset_a", 0);
        check_zero("reset_b", 1);
        rst = 1'b0;
        step(2);

        // Free-running dump.
        base = done_cnt_a;
        start_run(0, 1000, -1, 0, 111);
        finish_run("free", 0, base);

        // Backpressure while R5 (beat 6) is valid, cycles 13..15.
        base = done_cnt_a;
        start_run(0, 1000, 6, 3, 114);
        step(12);
        if_a.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            assert ({if_a.out_valid, if_a.out_data, if_a.out_kind, if_a.out_index} ===
                    {1'b1, 32'h0000_0019, 2'd1, 8'd5})
            else begin
                errors++;
                $error("FAIL bp_hold: got v=%0d data=%h kind=%0d idx=%0d, expected v=1 data=00000019 kind=1 idx=5",
                       if_a.out_valid, if_a.out_data, if_a.out_kind, if_a.out_index);
            end
            @(posedge clk);
            #1;
        end
        if_a.out_ready = 1'b1;
        finish_run("backpressure", 0, base);

        // Start pulses at cycle 10 and at the done cycle 111 are ignored.
        base = done_cnt_a;
        start_run(0, 1000, -1, 0, 111);
        step(9);
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        step(100);
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        finish_run("start_busy", 0, base);

        // Reset for one cycle while DM word 2 is being assembled.
        base = done_cnt_a;
        start_run(0, 35, -1, 0, -1);
        step(76);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_zero("reset_mid", 0);
        step(150);
        checks++;
        assert (done_cnt_a == base && qa.size() == 0)
        else begin
            errors++;
            $error("FAIL reset_abort: got done=%0d beats_left=%0d, expected done=0 beats_left=0",
                   done_cnt_a - base, qa.size());
        end

        // Restart after reset reproduces the full sequence.
        base = done_cnt_a;
        start_run(0, 1000, -1, 0, 111);
        finish_run("restart", 0, base);

        // Single-word configuration at byte address 0x100.
        base = done_cnt_b;
        start_run(1, 1000, -1, 0, 71);
        step(65);
        for (int i = 0; i < 4; i++) begin
            checks++;
            assert (dm_addr_b === 32'h0000_0100 + 32'(i))
            else begin
                errors++;
                $error("FAIL dm_sweep: got %h, expected %h", dm_addr_b, 32'h0000_0100 + 32'(i));
            end
            step(1);
        end
        finish_run("boundary", 1, base);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
